fp_wb_ctrl: RTL and testbench

FP_WB_CTRL -- requirements
Module: fp_wb_ctrl

---
 rtl/fp_wb_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_fp_wb_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_wb_ctrl.sv
// FPU writeback controller: tracks in-flight FPU ops in order and steers each
// result to the FP regfile or to the integer writeback port, accruing fflags.

package fp_wb_ctrl_pkg;

  localparam int unsigned RegAw = 5;
  localparam int unsigned DataW = 32;
  localparam int unsigned FlagW = 5;

  typedef struct packed {
    logic [RegAw-1:0] rd;
    logic             to_gpr;
  } pend_t;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic [FlagW-1:0] status;
    logic [RegAw-1:0] rd;
  } wb_t;

endpackage

module fp_wb_ctrl
  import fp_wb_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             issue_valid_i,
  input  logic [RegAw-1:0] issue_rd_i,
  input  logic             issue_to_gpr_i,
  output logic             issue_ready_o,
  input  logic             fpu_out_valid_i,
  output logic             fpu_out_ready_o,
  input  logic [DataW-1:0] fpu_result_i,
  input  logic [FlagW-1:0] fpu_status_i,
  input  logic             flush_i,
  output logic             fp_we_o,
  output logic [RegAw-1:0] fp_waddr_o,
  output logic [DataW-1:0] fp_wdata_o,
  output logic             gpr_we_o,
  output logic [RegAw-1:0] gpr_waddr_o,
  output logic [DataW-1:0] gpr_wdata_o,
  input  logic             gpr_wb_ready_i,
  output logic [FlagW-1:0] fflags_o,
  input  logic             fflags_clr_i,
  output logic             err_o,
  output logic             busy_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    WB_FP  = 2'd1,
    WB_GPR = 2'd2
  } state_e;

  pend_t            queue_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  state_e           state_q, state_d;
  wb_t              wb_q, wb_d;
  logic [FlagW-1:0] fflags_q, fflags_d;
  logic             err_q, err_d;

  pend_t            head_c;
  logic             full_c, empty_c, hs_c, push_c, pop_c, done_c;

  // Handshake, queue and commit qualifiers
  always_comb begin
    head_c  = queue_q[rptr_q];
    full_c  = (cnt_q == CntW'(DEPTH));
    empty_c = (cnt_q == '0);
    hs_c    = fpu_out_valid_i & fpu_out_ready_o;
    pop_c   = hs_c & ~empty_c & ~flush_i;
    // A retire in the same cycle frees a slot, so a full queue still takes the issue
    push_c  = issue_valid_i & (~full_c | pop_c) & ~flush_i;
    done_c  = ~flush_i & ((state_q == WB_FP) | ((state_q == WB_GPR) & gpr_wb_ready_i));
  end

  // Next-state logic for pointers, count, WB stage and flags
  always_comb begin
    state_d  = state_q;
    wb_d     = wb_q;
    cnt_d    = cnt_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    fflags_d = fflags_q;
    err_d    = 1'b0;

    if (flush_i) begin
      state_d = EMPTY;
      cnt_d   = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      fflags_d = (fflags_clr_i ? '0 : fflags_q) | (done_c ? wb_q.status : '0);
      err_d    = hs_c & empty_c;

      if (push_c) wptr_d = wptr_q + PtrW'(1);
      if (pop_c)  rptr_d = rptr_q + PtrW'(1);

      unique case ({push_c, pop_c})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase

      if (pop_c) begin
        wb_d.data   = fpu_result_i;
        wb_d.status = fpu_status_i;
        wb_d.rd     = head_c.rd;
      end

      unique case (state_q)
        EMPTY: begin
          if (pop_c) state_d = head_c.to_gpr ? WB_GPR : WB_FP;
        end
        WB_FP: begin
          if (pop_c) state_d = head_c.to_gpr ? WB_GPR : WB_FP;
          else       state_d = EMPTY;
        end
        WB_GPR: begin
          if (gpr_wb_ready_i) begin
            if (pop_c) state_d = head_c.to_gpr ? WB_GPR : WB_FP;
            else       state_d = EMPTY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= EMPTY;
      wb_q     <= '0;
      cnt_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      fflags_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wb_q     <= wb_d;
      cnt_q    <= cnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      fflags_q <= fflags_d;
      err_q    <= err_d;
    end
  end

  // Pending-op storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) queue_q[i] <= '0;
    end else if (push_c) begin
      queue_q[wptr_q] <= '{rd: issue_rd_i, to_gpr: issue_to_gpr_i};
    end
  end

  // Flush kills the write in its own cycle, so the enables are gated here
  assign fp_we_o         = (state_q == WB_FP) & ~flush_i;
  assign gpr_we_o        = (state_q == WB_GPR) & ~flush_i;
  assign fp_waddr_o      = wb_q.rd;
  assign fp_wdata_o      = wb_q.data;
  assign gpr_waddr_o     = wb_q.rd;
  assign gpr_wdata_o     = wb_q.data;
  assign fflags_o        = fflags_q;
  assign err_o           = err_q;
  assign issue_ready_o   = ~full_c;
  assign fpu_out_ready_o = (state_q == EMPTY) | (state_q == WB_FP) |
                           ((state_q == WB_GPR) & gpr_wb_ready_i);
  assign busy_o          = ~empty_c | (state_q != EMPTY);

endmodule

// File: tb/tb_fp_wb_ctrl.sv
// Bench for fp_wb_ctrl: directed scenarios with literal expectations, then
// random traffic checked every cycle against a queue-based reference model.

module tb_fp_wb_ctrl;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_i;
  logic        issue_to_gpr_i;
  logic        issue_ready_o;
  logic        fpu_out_valid_i;
  logic        fpu_out_ready_o;
  logic [31:0] fpu_result_i;
  logic [4:0]  fpu_status_i;
  logic        flush_i;
  logic        fp_we_o;
  logic [4:0]  fp_waddr_o;
  logic [31:0] fp_wdata_o;
  logic        gpr_we_o;
  logic [4:0]  gpr_waddr_o;
  logic [31:0] gpr_wdata_o;
  logic        gpr_wb_ready_i;
  logic [4:0]  fflags_o;
  logic        fflags_clr_i;
  logic        err_o;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  fp_wb_ctrl #(.DEPTH(DEPTH)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .issue_valid_i   (issue_valid_i),
    .issue_rd_i      (issue_rd_i),
    .issue_to_gpr_i  (issue_to_gpr_i),
    .issue_ready_o   (issue_ready_o),
    .fpu_out_valid_i (fpu_out_valid_i),
    .fpu_out_ready_o (fpu_out_ready_o),
    .fpu_result_i    (fpu_result_i),
    .fpu_status_i    (fpu_status_i),
    .flush_i         (flush_i),
    .fp_we_o         (fp_we_o),
    .fp_waddr_o      (fp_waddr_o),
    .fp_wdata_o      (fp_wdata_o),
    .gpr_we_o        (gpr_we_o),
    .gpr_waddr_o     (gpr_waddr_o),
    .gpr_wdata_o     (gpr_wdata_o),
    .gpr_wb_ready_i  (gpr_wb_ready_i),
    .fflags_o        (fflags_o),
    .fflags_clr_i    (fflags_clr_i),
    .err_o           (err_o),
    .busy_o          (busy_o)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of pending ops plus one pending write
  logic [5:0]  m_q[$];
  bit          m_wb_v, m_wb_gpr, m_err;
  logic [4:0]  m_wb_rd, m_wb_st, m_ff;
  logic [31:0] m_wb_data;

  always @(negedge clk_i) begin : compare
    int         sz;
    bit         exp_ready, hs, done, popped;
    logic [5:0] head;
    if (!rst_ni) begin
      m_q.delete();
      m_wb_v = 0; m_wb_gpr = 0; m_err = 0; m_ff = '0;
      m_wb_rd = '0; m_wb_st = '0; m_wb_data = '0;
      chk("rst fp_we", 32'(fp_we_o), 32'd0);
      chk("rst gpr_we", 32'(gpr_we_o), 32'd0);
      chk("rst fp_waddr", 32'(fp_waddr_o), 32'd0);
      chk("rst fp_wdata", fp_wdata_o, 32'd0);
      chk("rst gpr_waddr", 32'(gpr_waddr_o), 32'd0);
      chk("rst gpr_wdata", gpr_wdata_o, 32'd0);
      chk("rst fflags", 32'(fflags_o), 32'd0);
      chk("rst err", 32'(err_o), 32'd0);
      chk("rst busy", 32'(busy_o), 32'd0);
      chk("rst issue_ready", 32'(issue_ready_o), 32'd1);
    end else begin
      sz        = m_q.size();
      exp_ready = !m_wb_v || !m_wb_gpr || gpr_wb_ready_i;
      chk("issue_ready", 32'(issue_ready_o), 32'(sz != DEPTH));
      chk("out_ready", 32'(fpu_out_ready_o), 32'(exp_ready));
      chk("fp_we", 32'(fp_we_o), 32'(m_wb_v && !m_wb_gpr && !flush_i));
      chk("gpr_we", 32'(gpr_we_o), 32'(m_wb_v && m_wb_gpr && !flush_i));
      chk("we_exclusive", 32'(fp_we_o & gpr_we_o), 32'd0);
      if (m_wb_v && !m_wb_gpr) begin
        chk("fp_waddr", 32'(fp_waddr_o), 32'(m_wb_rd));
        chk("fp_wdata", fp_wdata_o, m_wb_data);
      end
      if (m_wb_v && m_wb_gpr) begin
        chk("gpr_waddr", 32'(gpr_waddr_o), 32'(m_wb_rd));
        chk("gpr_wdata", gpr_wdata_o, m_wb_data);
      end
      chk("fflags", 32'(fflags_o), 32'(m_ff));
      chk("err", 32'(err_o), 32'(m_err));
      chk("busy", 32'(busy_o), 32'(sz != 0 || m_wb_v));

      if (flush_i) begin
        m_q.delete();
        m_wb_v = 0;
        m_err  = 0;
      end else begin
        done   = m_wb_v && (!m_wb_gpr || gpr_wb_ready_i);
        hs     = fpu_out_valid_i && exp_ready;
        m_ff   = (fflags_clr_i ? 5'd0 : m_ff) | (done ? m_wb_st : 5'd0);
        m_err  = hs && (sz == 0);
        popped = hs && (sz != 0);
        if (popped) begin
          head      = m_q.pop_front();
          m_wb_v    = 1;
          m_wb_gpr  = head[0];
          m_wb_rd   = head[5:1];
          m_wb_data = fpu_result_i;
          m_wb_st   = fpu_status_i;
        end else if (done) begin
          m_wb_v = 0;
        end
        if (issue_valid_i && (sz < DEPTH || popped))
          m_q.push_back({issue_rd_i, issue_to_gpr_i});
      end
    end
  end

  task automatic idle();
    issue_valid_i   = 1'b0;
    issue_rd_i      = '0;
    issue_to_gpr_i  = 1'b0;
    fpu_out_valid_i = 1'b0;
    fpu_result_i    = '0;
    fpu_status_i    = '0;
    flush_i         = 1'b0;
    gpr_wb_ready_i  = 1'b1;
    fflags_clr_i    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic issue(input logic [4:0] rd, input logic to_gpr);
    issue_valid_i  = 1'b1;
    issue_rd_i     = rd;
    issue_to_gpr_i = to_gpr;
    tick();
    idle();
  endtask

  initial begin : stim
    logic [4:0] drain_rd [4];
    int         ph;
    rst_ni = 1'b0;
    idle();
    tick();
    #1;
    chk("reset issue_ready", 32'(issue_ready_o), 32'd1);
    chk("reset busy", 32'(busy_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    // FP op rd=3 with NX
    issue(5'd3, 1'b0);
    tick();
    fpu_out_valid_i = 1'b1; fpu_result_i = 32'h3F80_0000; fpu_status_i = 5'h01;
    tick();
    idle();
    #1;
    chk("d020 fp_we", 32'(fp_we_o), 32'd1);
    chk("d020 waddr", 32'(fp_waddr_o), 32'd3);
    chk("d020 wdata", fp_wdata_o, 32'h3F80_0000);
    tick();
    #1;
    chk("d020 fflags", 32'(fflags_o), 32'h01);
    chk("d020 fp_we off", 32'(fp_we_o), 32'd0);

    // GPR op rd=5 stalled three cycles
    issue(5'd5, 1'b1);
    gpr_wb_ready_i = 1'b0;
    fpu_out_valid_i = 1'b1; fpu_result_i = 32'hCAFE_0005; fpu_status_i = 5'h04;
    tick();
    fpu_out_valid_i = 1'b0; fpu_result_i = '0; fpu_status_i = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("d021 gpr_we held", 32'(gpr_we_o), 32'd1);
      chk("d021 waddr", 32'(gpr_waddr_o), 32'd5);
      chk("d021 wdata", gpr_wdata_o, 32'hCAFE_0005);
      chk("d021 out_ready stall", 32'(fpu_out_ready_o), 32'd0);
      tick();
    end
    gpr_wb_ready_i = 1'b1;
    #1;
    chk("d021 gpr_we 4th", 32'(gpr_we_o), 32'd1);
    chk("d021 out_ready", 32'(fpu_out_ready_o), 32'd1);
    tick();
    idle();
    #1;
    chk("d021 gpr_we done", 32'(gpr_we_o), 32'd0);
    chk("d021 fflags", 32'(fflags_o), 32'h05);

    // Fill to DEPTH, ignored 5th issue, issue+retire at full
    for (int i = 0; i < 4; i++) issue(5'(10 + i), 1'b0);
    #1;
    chk("d022 full ready", 32'(issue_ready_o), 32'd0);
    issue(5'd14, 1'b0);
    issue_valid_i = 1'b1; issue_rd_i = 5'd15;
    fpu_out_valid_i = 1'b1; fpu_result_i = 32'h0000_0A0A;
    tick();
    idle();
    #1;
    chk("d022 still full", 32'(issue_ready_o), 32'd0);
    chk("d022 waddr", 32'(fp_waddr_o), 32'd10);
    drain_rd[0] = 5'd11; drain_rd[1] = 5'd12; drain_rd[2] = 5'd13; drain_rd[3] = 5'd15;
    for (int i = 0; i < 4; i++) begin
      fpu_out_valid_i = 1'b1; fpu_result_i = 32'(100 + i);
      tick();
      #1;
      chk("d022 drain we", 32'(fp_we_o), 32'd1);
      chk("d022 drain waddr", 32'(fp_waddr_o), 32'(drain_rd[i]));
    end
    idle();
    tick();
    #1;
    chk("d022 idle busy", 32'(busy_o), 32'd0);

    // Back-to-back FP results rd=1,2,3
    for (int i = 1; i <= 3; i++) issue(5'(i), 1'b0);
    for (int i = 1; i <= 3; i++) begin
      fpu_out_valid_i = 1'b1; fpu_result_i = 32'(i * 7);
      tick();
      #1;
      chk("d023 we", 32'(fp_we_o), 32'd1);
      chk("d023 waddr", 32'(fp_waddr_o), 32'(i));
    end
    idle();
    tick();

    // Flush with two pending and a stalled GPR write, then an orphan result
    for (int i = 7; i <= 9; i++) issue(5'(i), 1'b1);
    gpr_wb_ready_i = 1'b0;
    fpu_out_valid_i = 1'b1; fpu_result_i = 32'd77; fpu_status_i = 5'h08;
    tick();
    fpu_out_valid_i = 1'b0; fpu_status_i = '0;
    #1;
    chk("d024 stalled", 32'(gpr_we_o), 32'd1);
    flush_i = 1'b1; gpr_wb_ready_i = 1'b1;
    #1;
    chk("d024 flush suppress", 32'(gpr_we_o), 32'd0);
    tick();
    idle();
    #1;
    chk("d024 busy", 32'(busy_o), 32'd0);
    chk("d024 fflags kept", 32'(fflags_o), 32'h05);
    chk("d024 no write", 32'(gpr_we_o | fp_we_o), 32'd0);
    fpu_out_valid_i = 1'b1; fpu_result_i = 32'd1; fpu_status_i = 5'h1F;
    tick();
    idle();
    #1;
    chk("d024 err pulse", 32'(err_o), 32'd1);
    chk("d024 orphan no we", 32'(fp_we_o | gpr_we_o), 32'd0);
    chk("d024 orphan flags", 32'(fflags_o), 32'h05);
    tick();
    #1;
    chk("d024 err one cycle", 32'(err_o), 32'd0);

    // Clear coinciding with an NV commit
    issue(5'd4, 1'b0);
    fpu_out_valid_i = 1'b1; fpu_result_i = 32'h7FC0_0000; fpu_status_i = 5'h10;
    tick();
    idle();
    fflags_clr_i = 1'b1;
    #1;
    chk("d025 fp_we", 32'(fp_we_o), 32'd1);
    tick();
    idle();
    #1;
    chk("d025 fflags", 32'(fflags_o), 32'h10);

    // Random traffic with alternating fill/drain bias and one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      ph = ((i % 400) < 200) ? 1 : 0;
      issue_valid_i   = $urandom_range(0, 99) < (ph != 0 ? 70 : 30);
      issue_rd_i      = 5'($urandom_range(0, 31));
      issue_to_gpr_i  = 1'($urandom_range(0, 1));
      fpu_out_valid_i = $urandom_range(0, 99) < (ph != 0 ? 30 : 60);
      fpu_result_i    = $urandom;
      fpu_status_i    = 5'($urandom_range(0, 31));
      flush_i         = $urandom_range(0, 99) < 2;
      gpr_wb_ready_i  = $urandom_range(0, 99) < 60;
      fflags_clr_i    = $urandom_range(0, 99) < 4;
      if (i == 1500) rst_ni = 1'b0;
      if (i == 1503) rst_ni = 1'b1;
      tick();
    end
    idle();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
